// File: rtl/multi_issue_dmem_arbiter_pkg.sv
// Shared defaults and helpers for the multi-issue DMEM arbiter.
// Default values stand in for the project-wide configuration header.
package multi_issue_dmem_arbiter_pkg;

    localparam int DEF_NCORES        = 4;
    localparam int DEF_ADDR_WIDTH    = 12;
    localparam int DEF_NPORTS        = 2;
    localparam int DEF_CONFLICT_MODE = 0;
    localparam int DEF_BANK_BITS     = 2;
    localparam int DEF_MAX_WAIT      = 7;

    typedef enum logic {
        CONFLICT_WORD = 1'b0,
        CONFLICT_BANK = 1'b1
    } conflict_mode_e;

    function automatic conflict_mode_e conflict_mode(input int mode);
        return (mode == 0) ? CONFLICT_WORD : CONFLICT_BANK;
    endfunction

endpackage

// File: rtl/multi_issue_dmem_arbiter_rr_find_first.sv
// Rotating priority finder: first set bit of (mask & ~excl) scanning upward from ptr,
// wrapping at N. Returns found plus the binary index.
module multi_issue_dmem_arbiter_rr_find_first
    import multi_issue_dmem_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] ptr_i,
    input  logic [N-1:0]  excl_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    logic [N-1:0]   cand;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW:0]    sum;

    always_comb begin
        cand    = mask_i & ~excl_i;
        // rot[i] holds cand[(ptr + i) mod N]
        dbl     = {cand, cand} >> ptr_i;
        rot     = dbl[N-1:0];
        found_o = 1'b0;
        idx_o   = '0;
        sum     = '0;
        for (int i = 0; i < N; i++) begin
            if (!found_o && rot[i]) begin
                found_o = 1'b1;
                sum     = {1'b0, ptr_i} + (IW+1)'(i);
                if (sum >= (IW+1)'(N)) begin
                    sum = sum - (IW+1)'(N);
                end
                idx_o = sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/multi_issue_dmem_arbiter.sv
// Round-robin DMEM arbiter granting up to NPORTS conflict-free requests per cycle,
// with urgent (aged) requesters scanned ahead of the normal rotation.
module multi_issue_dmem_arbiter
    import multi_issue_dmem_arbiter_pkg::*;
#(
    parameter int NCORES        = DEF_NCORES,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int NPORTS        = DEF_NPORTS,
    parameter int CONFLICT_MODE = DEF_CONFLICT_MODE,
    parameter int BANK_BITS     = DEF_BANK_BITS,
    parameter int MAX_WAIT      = DEF_MAX_WAIT
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             mem_ready_i,
    input  logic [NCORES-1:0]                req_valid_i,
    input  logic [NCORES*ADDR_WIDTH-1:0]     req_addr_packed_i,
    output logic [NCORES-1:0]                gnt_o,
    output logic [NPORTS-1:0]                port_valid_o,
    output logic [NPORTS*$clog2(NCORES)-1:0] port_sel_o,
    output logic [$clog2(NCORES)-1:0]        rr_ptr_o
);

    localparam int IW  = $clog2(NCORES);
    localparam int KW  = ADDR_WIDTH - 2;
    localparam int CW  = $clog2(NPORTS + 1);
    localparam int WW  = $clog2(MAX_WAIT + 1);
    localparam int NST = 2 * NPORTS;
    localparam conflict_mode_e MODE = conflict_mode(CONFLICT_MODE);

    logic [NCORES-1:0]      gnt_q, gnt_d;
    logic [NPORTS-1:0]      port_valid_q, port_valid_d;
    logic [NPORTS*IW-1:0]   port_sel_q, port_sel_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [WW-1:0]          wait_q [NCORES];
    logic [WW-1:0]          wait_d [NCORES];

    logic [NCORES-1:0]      elig, urgent, normal;
    logic [KW-1:0]          key [NCORES];
    logic [NCORES-1:0]      key_match [NCORES];

    logic [NST-1:0]         take_v;
    logic [NST*IW-1:0]      idx_v;
    logic [NST*CW-1:0]      pos_v;

    logic [NCORES-1:0]      kept;
    logic [NPORTS-1:0]      pv_sel;
    logic [NPORTS*IW-1:0]   ps_sel;
    logic                   norm_kept;
    logic [IW-1:0]          last_norm;
    logic [IW-1:0]          rr_inc;

    logic                   unused_addr_bits;
    logic                   unused_tail;

    assign unused_addr_bits = ^req_addr_packed_i;

    // Cores whose grant is currently visible sit out this cycle's selection.
    always_comb begin
        elig   = req_valid_i & ~gnt_q;
        urgent = '0;
        for (int k = 0; k < NCORES; k++) begin
            urgent[k] = elig[k] && (wait_q[k] == WW'(MAX_WAIT));
        end
        normal = elig & ~urgent;
    end

    for (genvar k = 0; k < NCORES; k++) begin : g_key
        if (MODE == CONFLICT_BANK) begin : g_bank
            assign key[k] = KW'(req_addr_packed_i[ADDR_WIDTH*k+2 +: BANK_BITS]);
        end else begin : g_word
            assign key[k] = req_addr_packed_i[ADDR_WIDTH*k+2 +: KW];
        end
    end

    always_comb begin
        for (int j = 0; j < NCORES; j++) begin
            key_match[j] = '0;
            for (int k = 0; k < NCORES; k++) begin
                key_match[j][k] = (key[j] == key[k]);
            end
        end
    end

    // Stages 0..NPORTS-1 scan the urgent group, the rest the normal group. A kept
    // core excludes every core sharing its key from all later stages.
    for (genvar s = 0; s < NST; s++) begin : g_stage
        logic [NCORES-1:0] mask;
        logic [NCORES-1:0] excl_in, excl_out;
        logic [CW-1:0]     cnt_in, cnt_out;
        logic              found, take;
        logic [IW-1:0]     idx;

        if (s < NPORTS) begin : g_urg
            assign mask = urgent;
        end else begin : g_norm
            assign mask = normal;
        end

        if (s == 0) begin : g_first
            assign excl_in = '0;
            assign cnt_in  = '0;
        end else begin : g_chain
            assign excl_in = g_stage[s-1].excl_out;
            assign cnt_in  = g_stage[s-1].cnt_out;
        end

        multi_issue_dmem_arbiter_rr_find_first #(
            .N  (NCORES),
            .IW (IW)
        ) u_find (
            .mask_i  (mask),
            .ptr_i   (rr_ptr_q),
            .excl_i  (excl_in),
            .found_o (found),
            .idx_o   (idx)
        );

        assign take     = found && (cnt_in < CW'(NPORTS));
        assign excl_out = take ? (excl_in | key_match[idx]) : excl_in;
        assign cnt_out  = cnt_in + CW'(take);

        assign take_v[s]           = take;
        assign idx_v[s*IW +: IW]   = idx;
        assign pos_v[s*CW +: CW]   = cnt_in;
    end

    assign unused_tail = ^{g_stage[NST-1].excl_out, g_stage[NST-1].cnt_out};

    always_comb begin
        kept      = '0;
        pv_sel    = '0;
        ps_sel    = '0;
        norm_kept = 1'b0;
        last_norm = '0;
        for (int s = 0; s < NST; s++) begin
            if (take_v[s]) begin
                kept[idx_v[s*IW +: IW]] = 1'b1;
                for (int p = 0; p < NPORTS; p++) begin
                    if (pos_v[s*CW +: CW] == CW'(p)) begin
                        pv_sel[p]           = 1'b1;
                        ps_sel[p*IW +: IW]  = idx_v[s*IW +: IW];
                    end
                end
                if (s >= NPORTS) begin
                    norm_kept = 1'b1;
                    last_norm = idx_v[s*IW +: IW];
                end
            end
        end
        rr_inc = (last_norm == IW'(NCORES - 1)) ? '0 : last_norm + IW'(1);
    end

    always_comb begin
        gnt_d        = '0;
        port_valid_d = '0;
        port_sel_d   = '0;
        rr_ptr_d     = rr_ptr_q;
        if (mem_ready_i) begin
            gnt_d        = kept;
            port_valid_d = pv_sel;
            port_sel_d   = ps_sel;
            // Urgent-only grants leave the rotation where it was.
            if (norm_kept) begin
                rr_ptr_d = rr_inc;
            end
        end
        for (int k = 0; k < NCORES; k++) begin
            wait_d[k] = wait_q[k];
            if (!req_valid_i[k]) begin
                wait_d[k] = '0;
            end else if (mem_ready_i && kept[k]) begin
                wait_d[k] = '0;
            end else if (mem_ready_i && elig[k] && (wait_q[k] != WW'(MAX_WAIT))) begin
                wait_d[k] = wait_q[k] + WW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_q        <= '0;
            port_valid_q <= '0;
            port_sel_q   <= '0;
            rr_ptr_q     <= '0;
            for (int k = 0; k < NCORES; k++) begin
                wait_q[k] <= '0;
            end
        end else begin
            gnt_q        <= gnt_d;
            port_valid_q <= port_valid_d;
            port_sel_q   <= port_sel_d;
            rr_ptr_q     <= rr_ptr_d;
            for (int k = 0; k < NCORES; k++) begin
                wait_q[k] <= wait_d[k];
            end
        end
    end

    assign gnt_o        = gnt_q;
    assign port_valid_o = port_valid_q;
    assign port_sel_o   = port_sel_q;
    assign rr_ptr_o     = rr_ptr_q;

endmodule

// File: doc/multi_issue_dmem_arbiter.md
Name: multi_issue_dmem_arbiter

Overview:
Round-robin arbiter granting up to NPORTS data-memory requests per cycle from NCORES cores. It generalises the dual-issue arbiter in four ways: issue width is parametrised, the round-robin pointer is held internally, an anti-starvation ageing path is added, and a per-core grant handshake is added. Conflicting requests (same word, or same bank) are skipped, and the scan continues to the next candidate instead of dropping the port. Sits between the core request buses and the multi-ported DMEM; grants are registered.

Parameters:
NCORES, `NCORES, number of requesting cores (>=2)
ADDR_WIDTH, `DMEM_ADDRW, byte address width per request
NPORTS, 2, memory ports = max grants per cycle (1..NCORES)
CONFLICT_MODE, 0, 0 = word conflict (addr[ADDR_WIDTH-1:2]); 1 = bank conflict (addr[BANK_BITS+1:2])
BANK_BITS, 2, bank index width for CONFLICT_MODE=1
MAX_WAIT, 7, cycles of un-granted waiting before a core becomes urgent (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
mem_ready_i  in  1  DMEM accepts grants this cycle
req_valid_i  in  NCORES  per-core request, held until granted
req_addr_packed_i  in  NCORES*ADDR_WIDTH  core k address at [ADDR_WIDTH*(k+1)-1 : ADDR_WIDTH*k]
gnt_o  out  NCORES  one-hot-per-core grant pulse (registered)
port_valid_o  out  NPORTS  port p carries a granted request (registered)
port_sel_o  out  NPORTS*$clog2(NCORES)  core index on port p (registered)
rr_ptr_o  out  $clog2(NCORES)  current round-robin pointer (debug)

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: gnt_o=0, port_valid_o=0, port_sel_o=0, rr_ptr_o=0, all wait counters 0. A reset asserted mid-operation drops all pending grants the next edge.
- Eligible set E = req_valid_i & ~gnt_o. A core is masked in the cycle its grant is visible. Each core therefore achieves at most one grant per 2 cycles.
- Urgent set U = E & (wait_cnt == MAX_WAIT).
- Selection (combinational, one greedy pass):
  - Scan order: U first, then E & ~U. Each group is scanned in rotated order starting at rr_ptr.
  - Keep a candidate only if its conflict key differs from every key already kept. Stop after NPORTS keeps.
  - Kept candidates fill ports 0..NPORTS-1 in scan order.
- Registered update, when mem_ready_i=1:
  - gnt_o[k]=1 for each kept k.
  - port_valid_o[p] and port_sel_o[p] are loaded; unused ports get valid=0, sel=0.
  - rr_ptr advances to (index of last kept non-urgent core + 1) mod NCORES. If only urgent cores or no cores are kept, rr_ptr is unchanged.
- When mem_ready_i=0: gnt_o and port_valid_o are 0 next cycle; rr_ptr and wait counters hold.
- Latency: request visible at edge n, grant visible after edge n+1 (1 cycle).
- Wait counter k:
  - Cleared when gnt_o[k] is set or when req_valid_i[k]=0.
  - Otherwise incremented each mem_ready_i=1 cycle where E[k]=1 and k is not kept.
  - Saturates at MAX_WAIT.
- Invariants:
  - Never two ports with the same sel.
  - Never two valid ports with equal conflict key.
  - popcount(gnt_o) == popcount(port_valid_o).
- Boundaries:
  - All NCORES requesting the same word: exactly 1 grant per cycle, rotating.
  - rr_ptr = NCORES-1 wraps to 0.
  - NPORTS = NCORES with no conflicts: all requests are granted.
  - A core dropping its request while urgent loses urgency immediately.

Decomposition:
- Shared header config.vh gains `DMEM_NPORTS, `ARB_MAX_WAIT, `ARB_CONFLICT_MODE defaults. NCORES and DMEM_ADDRW are reused.
- One natural sub-module, rr_find_first: given mask, pointer and exclude vector, it returns found plus a binary index. It is instantiated iteratively (NPORTS x 2 groups) in a generate loop, with the conflict-exclude vector accumulated between stages.

Test Plan:
- NCORES=4, NPORTS=2, mode 0; reset, then req_valid=4'b1111 with addrs 0x000, 0x004, 0x008, 0x00C held -> cycle1 gnt=0011 (ports sel 0,1); cycle2 gnt=1100 (sel 2,3); rr_ptr 0 -> 2 -> 0.
- All four cores at addr 0x010 held continuously -> exactly one grant per cycle, port_valid=01, sel rotates 0,1,2,3,0; port 1 is never valid.
- Mode 1, BANK_BITS=2; cores 0,1,2 at 0x000, 0x010, 0x004 -> port0=core0, core1 is skipped (same bank 0), port1=core2; core1 is granted the next cycle.
- MAX_WAIT=2; core 3 requests while cores 0-2 are saturated by their own conflicting stream -> core 3 wait counter reaches 2; next selection places core3 on port 0 ahead of rr order; rr_ptr is unchanged by that grant.
- mem_ready_i=0 for 3 cycles with requests pending -> gnt_o=0, port_valid=0; rr_ptr and counters frozen; resumes with identical selection when ready returns.
- rst_i asserted in the cycle after a grant -> next edge all outputs 0 and rr_ptr=0; held requests are re-granted starting from core 0.
